bf16_sub_seq: RTL and testbench
===============================

BF16_SUB_SEQ -- requirements
Module: bf16_sub_seq

Interface
REQ-001 SHALL have parameters EXP_SIZE = 8 (exponent width), MANTISSA_SIZE = 7 (stored fraction width) and SIGN_SIZE = 1 (sign width).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port a, input, 16 bits: bfloat16 minuend {sign, exp[7:0], frac[6:0]}.
REQ-005 SHALL have port b, input, 16 bits: bfloat16 subtrahend, same format as a.
REQ-006 SHALL have port in_valid, input, 1 bit: a and b are valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an operand pair.
REQ-008 SHALL have port diff, output, 16 bits: bfloat16 result of a - b.
REQ-009 SHALL have port out_valid, output, 1 bit: diff is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts diff.

Function
REQ-011 SHALL implement the FSM IDLE -> ALIGN -> ARITH -> NORM -> DONE -> IDLE with a single operation in flight.
REQ-012 SHALL drive in_ready high only in IDLE; a transfer occurs when in_valid and in_ready are both high, capturing a and b with b's sign inverted.
REQ-013 SHALL treat an operand with exp == 0 as zero, and apply the implicit leading 1 to every other operand; denormals are not supported.
REQ-014 ALIGN SHALL take one cycle: select the larger-exponent operand as the result exponent and sign; right-shift the smaller 8-bit mantissa by the exponent difference, with differences of 8 or more giving 0; truncate with no rounding.
REQ-015 ARITH SHALL take one cycle and produce a 9-bit magnitude.
  - Effective signs equal: add the magnitudes; on carry, shift right 1 and increment the exponent.
  - Signs differ: subtract smaller from larger; sign follows the larger magnitude.
  - Equal exponents and equal mantissas with signs differing: result +0 (0x0000).
REQ-016 NORM SHALL, while mant[7] == 0 and mant != 0, shift left by one bit and decrement the exponent, one bit per cycle, with at most 7 shifts; it SHALL go to DONE when mant[7] == 1 or mant == 0.
REQ-017 If the exponent would reach 0 during NORM, or the magnitude is 0, the result SHALL be +0.
REQ-018 If the result exponent is >= 255 (including carry from 254), the result SHALL be {sign, 8'hFF, 7'b0}; NaN is not propagated.
REQ-019 Latency SHALL be 3 + k cycles from the accepting edge to out_valid high, where k is the number of NORM shifts (0..7), giving a maximum of 10.
REQ-020 In DONE, out_valid SHALL be 1 and diff SHALL be held stable until out_ready is high; at the handshake edge the FSM SHALL return to IDLE.
REQ-021 DONE with out_ready already high SHALL complete in one cycle; there is no same-cycle accept of a new operand, so in_ready becomes high the cycle after the handshake.
REQ-022 out_valid and diff SHALL be registered outputs; diff is don't-care while out_valid is low and is driven to 0 by the design.

Reset
REQ-023 rst high at any clock edge SHALL force IDLE, in_ready = 1, out_valid = 0, diff = 16'h0000, and clear all datapath registers.
REQ-024 Reset mid-operation SHALL discard the in-flight operation with no output produced.

Structure
REQ-025 A shared package bf16_pkg SHALL hold EXP_SIZE, MANTISSA_SIZE, SIGN_SIZE, BF16_POS_ZERO (16'h0000), the exponent all-ones constant (8'hFF) and the FSM state enumeration.
REQ-026 Alignment logic SHALL be one sub-module, bf16_align: combinational, taking both exponents and mantissas and returning the shifted mantissas, result exponent and swap flag.

Verification
REQ-027 Test: a = 0x4040 (3.0), b = 0x3F80 (1.0) -> diff = 0x4000 (2.0), out_valid 3 cycles after accept.
REQ-028 Test: a = 0x3F81, b = 0x3F80 -> diff = 0x3C00 (2^-7), with 7 NORM shifts and out_valid 10 cycles after accept.
REQ-029 Test: a = 0x3F80, b = 0xBF80 (1.0 - (-1.0)) -> diff = 0x4000 via the carry path; a = 0x3F80, b = 0x3F80 -> diff = 0x0000.
REQ-030 Test: a = 0x7F7F, b = 0xFF7F -> diff = 0x7F80 (+inf); a = 0x4000, b = 0x0000 -> diff = 0x4000.
REQ-031 Test: hold out_ready low for 5 cycles in DONE -> out_valid and diff stable, in_ready low; raise out_ready -> in_ready high on the next cycle.
REQ-032 Test: assert rst during NORM of the 0x3F81 - 0x3F80 case -> next cycle in_ready = 1, out_valid = 0, diff = 0x0000, and no result is emitted.

Source files
------------

// File: rtl/bf16_pkg.sv
// Shared constants and FSM state encoding for the sequential bfloat16 subtractor.
package bf16_pkg;

  localparam int EXP_SIZE      = 8;
  localparam int MANTISSA_SIZE = 7;
  localparam int SIGN_SIZE     = 1;

  localparam logic [15:0] BF16_POS_ZERO = 16'h0000;
  localparam logic [7:0]  EXP_ALL_ONES  = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ARITH,
    S_NORM,
    S_DONE
  } state_t;

endpackage

// File: rtl/bf16_align.sv
// Combinational exponent alignment: picks the larger-exponent operand and
// right-shifts the other mantissa by the exponent difference (truncating).
module bf16_align
  import bf16_pkg::*;
(
  input  logic [EXP_SIZE-1:0]    expA_i,
  input  logic [EXP_SIZE-1:0]    expB_i,
  input  logic [MANTISSA_SIZE:0] mantA_i,
  input  logic [MANTISSA_SIZE:0] mantB_i,
  output logic [MANTISSA_SIZE:0] bigMant_o,
  output logic [MANTISSA_SIZE:0] smallMant_o,
  output logic [EXP_SIZE-1:0]    exp_o,
  output logic                   swap_o
);

  localparam logic [EXP_SIZE-1:0] SHIFT_LIMIT = EXP_SIZE'(MANTISSA_SIZE + 1);

  logic [EXP_SIZE-1:0]    expDiff;
  logic [MANTISSA_SIZE:0] smallRaw;

  always_comb begin
    swap_o = (expB_i > expA_i);
    if (swap_o) begin
      exp_o     = expB_i;
      expDiff   = expB_i - expA_i;
      bigMant_o = mantB_i;
      smallRaw  = mantA_i;
    end else begin
      exp_o     = expA_i;
      expDiff   = expA_i - expB_i;
      bigMant_o = mantA_i;
      smallRaw  = mantB_i;
    end
    // Shifting by the full mantissa width or more leaves nothing behind.
    if (expDiff >= SHIFT_LIMIT) begin
      smallMant_o = '0;
    end else begin
      smallMant_o = smallRaw >> expDiff;
    end
  end

endmodule

// File: rtl/bf16_sub_seq.sv
// Multi-cycle bfloat16 subtractor (a - b): align, add/subtract, then normalise
// one bit per cycle, with a valid/ready handshake on both sides.
module bf16_sub_seq #(
  parameter int EXP_SIZE      = bf16_pkg::EXP_SIZE,
  parameter int MANTISSA_SIZE = bf16_pkg::MANTISSA_SIZE,
  parameter int SIGN_SIZE     = bf16_pkg::SIGN_SIZE
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [SIGN_SIZE+EXP_SIZE+MANTISSA_SIZE-1:0] a,
  input  logic [SIGN_SIZE+EXP_SIZE+MANTISSA_SIZE-1:0] b,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [SIGN_SIZE+EXP_SIZE+MANTISSA_SIZE-1:0] diff,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  import bf16_pkg::*;

  localparam int W  = SIGN_SIZE + EXP_SIZE + MANTISSA_SIZE;
  localparam int MW = MANTISSA_SIZE + 1;
  localparam int AW = MW + 1;
  localparam int XW = EXP_SIZE + 1;
  localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_SIZE{1'b1}}};

  state_t          state_q, state_d;
  logic [W-1:0]    opA_q, opA_d, opB_q, opB_d;
  logic [MW-1:0]   bigMant_q, bigMant_d, smallMant_q, smallMant_d;
  logic            bigSign_q, bigSign_d, smallSign_q, smallSign_d;
  logic [XW-1:0]   exp_q, exp_d;
  logic [AW-1:0]   mant_q, mant_d;
  logic            sign_q, sign_d;
  logic [W-1:0]    diff_q, diff_d;
  logic            outValid_q, outValid_d;

  logic [EXP_SIZE-1:0] expA, expB, alExp;
  logic [MW-1:0]       mantA, mantB, alBig, alSmall;
  logic                alSwap;
  logic [AW-1:0]       sum;

  // A zero exponent means zero; denormal fractions are discarded.
  assign expA  = opA_q[W-2 -: EXP_SIZE];
  assign expB  = opB_q[W-2 -: EXP_SIZE];
  assign mantA = (expA == '0) ? '0 : {1'b1, opA_q[MANTISSA_SIZE-1:0]};
  assign mantB = (expB == '0) ? '0 : {1'b1, opB_q[MANTISSA_SIZE-1:0]};

  bf16_align uAlign (
    .expA_i      (expA),
    .expB_i      (expB),
    .mantA_i     (mantA),
    .mantB_i     (mantB),
    .bigMant_o   (alBig),
    .smallMant_o (alSmall),
    .exp_o       (alExp),
    .swap_o      (alSwap)
  );

  assign in_ready  = (state_q == S_IDLE);
  assign diff      = diff_q;
  assign out_valid = outValid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      opA_q       <= '0;
      opB_q       <= '0;
      bigMant_q   <= '0;
      smallMant_q <= '0;
      bigSign_q   <= 1'b0;
      smallSign_q <= 1'b0;
      exp_q       <= '0;
      mant_q      <= '0;
      sign_q      <= 1'b0;
      diff_q      <= BF16_POS_ZERO;
      outValid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      bigMant_q   <= bigMant_d;
      smallMant_q <= smallMant_d;
      bigSign_q   <= bigSign_d;
      smallSign_q <= smallSign_d;
      exp_q       <= exp_d;
      mant_q      <= mant_d;
      sign_q      <= sign_d;
      diff_q      <= diff_d;
      outValid_q  <= outValid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    bigMant_d   = bigMant_q;
    smallMant_d = smallMant_q;
    bigSign_d   = bigSign_q;
    smallSign_d = smallSign_q;
    exp_d       = exp_q;
    mant_d      = mant_q;
    sign_d      = sign_q;
    diff_d      = diff_q;
    outValid_d  = outValid_q;
    sum         = {1'b0, bigMant_q} + {1'b0, smallMant_q};

    case (state_q)
      S_IDLE: begin
        // Subtraction becomes addition of b with its sign flipped.
        if (in_valid) begin
          opA_d   = a;
          opB_d   = {~b[W-1], b[W-2:0]};
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        bigMant_d   = alBig;
        smallMant_d = alSmall;
        exp_d       = {1'b0, alExp};
        bigSign_d   = alSwap ? opB_q[W-1] : opA_q[W-1];
        smallSign_d = alSwap ? opA_q[W-1] : opB_q[W-1];
        state_d     = S_ARITH;
      end
      S_ARITH: begin
        if (bigSign_q == smallSign_q) begin
          sign_d = bigSign_q;
          if (sum[AW-1]) begin
            mant_d = sum >> 1;
            exp_d  = exp_q + XW'(1);
          end else begin
            mant_d = sum;
          end
        end else if (bigMant_q == smallMant_q) begin
          mant_d = '0;
          sign_d = 1'b0;
        end else if (bigMant_q > smallMant_q) begin
          mant_d = {1'b0, bigMant_q - smallMant_q};
          sign_d = bigSign_q;
        end else begin
          mant_d = {1'b0, smallMant_q - bigMant_q};
          sign_d = smallSign_q;
        end
        state_d = S_ARITH == S_ARITH ? S_NORM : S_NORM;
      end
      S_NORM: begin
        if (mant_q == '0) begin
          diff_d     = BF16_POS_ZERO;
          outValid_d = 1'b1;
          state_d    = S_DONE;
        end else if (mant_q[MW-1]) begin
          diff_d     = (exp_q >= EXP_MAX) ?
                       {sign_q, EXP_ALL_ONES, {MANTISSA_SIZE{1'b0}}} :
                       {sign_q, exp_q[EXP_SIZE-1:0], mant_q[MANTISSA_SIZE-1:0]};
          outValid_d = 1'b1;
          state_d    = S_DONE;
        end else if (exp_q <= XW'(1)) begin
          // The next shift would underflow the exponent: flush to +0.
          diff_d     = BF16_POS_ZERO;
          outValid_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - XW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          outValid_d = 1'b0;
          diff_d     = BF16_POS_ZERO;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bf16_sub_seq.sv
// Scoreboard bench for bf16_sub_seq: the driver queues hand-computed results,
// a negedge monitor pops and checks value and latency when out_valid appears.
module tb_bf16_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] diff;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [15:0] diff;
    int          lat;
    int          acceptCyc;
  } expect_t;

  expect_t sbQ[$];
  int      checks = 0;
  int      passes = 0;
  int      cyc = 0;
  bit      outPending = 1'b0;
  int      acc;

  localparam int NVEC = 13;
  logic [15:0] vecA [NVEC] = '{16'h4040, 16'h3F81, 16'h3F80, 16'h3F80, 16'h7F7F,
                               16'h4000, 16'h0000, 16'h4040, 16'h4300, 16'h4380,
                               16'h7F00, 16'h0181, 16'h3F80};
  logic [15:0] vecB [NVEC] = '{16'h3F80, 16'h3F80, 16'hBF80, 16'h3F80, 16'hFF7F,
                               16'h0000, 16'h4000, 16'h3F00, 16'h3F80, 16'h3F80,
                               16'hFF00, 16'h0180, 16'h4000};
  logic [15:0] vecD [NVEC] = '{16'h4000, 16'h3C00, 16'h4000, 16'h0000, 16'h7F80,
                               16'h4000, 16'hC000, 16'h4020, 16'h42FE, 16'h4380,
                               16'h7F80, 16'h0000, 16'hBF80};
  int          vecL [NVEC] = '{3, 10, 3, 3, 3, 3, 3, 3, 4, 3, 3, 5, 4};

  bf16_sub_seq dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .diff      (diff),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Waits for in_ready, transfers one operand pair and optionally queues the result.
  task automatic applyStimulus(input logic [15:0] opA, input logic [15:0] opB,
                               input logic [15:0] expDiff, input int expLat,
                               input bit track, output int acceptCyc);
    int waitCnt;
    expect_t e;
    waitCnt = 0;
    acceptCyc = -1;
    @(negedge clk);
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!in_ready) begin
      checkOutput("inReadyTimeout", in_ready, 1);
      return;
    end
    a = opA;
    b = opB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    acceptCyc = cyc;
    if (track) begin
      e.diff = expDiff;
      e.lat = expLat;
      e.acceptCyc = cyc;
      sbQ.push_back(e);
    end
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    expect_t e;
    if (rst) begin
      outPending = 1'b0;
    end else if (out_valid && !outPending) begin
      outPending = 1'b1;
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedOutput", out_valid, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("diff", diff, e.diff);
        checkOutput("latency", cyc - e.acceptCyc, e.lat);
      end
    end else if (!out_valid) begin
      outPending = 1'b0;
    end
  end

  initial begin
    int waitCnt;
    rst = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("resetInReady", in_ready, 1);
    checkOutput("resetOutValid", out_valid, 0);
    checkOutput("resetDiff", diff, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecA[i], vecB[i], vecD[i], vecL[i], 1'b1, acc);
    end

    // Back-pressure: result must hold while out_ready is low.
    waitCnt = 0;
    while (!in_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    out_ready = 1'b0;
    applyStimulus(16'h4040, 16'h3F80, 16'h4000, 3, 1'b1, acc);
    waitCnt = 0;
    while (!out_valid && waitCnt < 20) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("stallOutValidSeen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stallOutValid", out_valid, 1);
      checkOutput("stallDiff", diff, 16'h4000);
      checkOutput("stallInReady", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("postHandshakeInReady", in_ready, 1);
    checkOutput("postHandshakeOutValid", out_valid, 0);

    // Reset during normalisation must discard the operation.
    applyStimulus(16'h3F81, 16'h3F80, 16'h3C00, 10, 1'b0, acc);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midResetInReady", in_ready, 1);
    checkOutput("midResetOutValid", out_valid, 0);
    checkOutput("midResetDiff", diff, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    checkOutput("noOutputAfterReset", out_valid, 0);

    applyStimulus(16'h4040, 16'h3F00, 16'h4020, 3, 1'b1, acc);

    waitCnt = 0;
    while ((sbQ.size() != 0 || out_valid) && waitCnt < 100) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("scoreboardDrained", sbQ.size(), 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
